// File: rtl/fetch_btb_stage_pkg.sv
// Shared constants and types for the fetch stage and its branch target buffer.
// Holds the bubble instruction, 2-bit counter encodings and the default reset PC.
// Also provides the saturating counter step used by the BTB.
package fetch_btb_stage_pkg;

    localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Saturating step of a 2-bit direction counter towards the resolved outcome.
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        n = c;
        if (taken && (c != ST)) begin
            n = c + 2'b01;
        end else if (!taken && (c != SNT)) begin
            n = c - 2'b01;
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_btb_stage_btb_table.sv
// Direct-mapped BTB: combinational lookup port, synchronous update port.
// Lookup is zero latency and reads pre-update contents when indices collide.
// No backpressure; an update is accepted every cycle it is presented.
module btb_table
    import fetch_btb_stage_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IDX_W = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [IDX_W-1:0]          lk_idx_i,
    input  logic [PC_W-IDX_W-3:0]     lk_tag_i,
    output logic                      lk_pred_taken_o,
    output logic [PC_W-1:0]           lk_pred_target_o,
    input  logic                      upd_en_i,
    input  logic [IDX_W-1:0]          upd_idx_i,
    input  logic [PC_W-IDX_W-3:0]     upd_tag_i,
    input  logic                      upd_taken_i,
    input  logic [PC_W-1:0]           upd_target_i
);

    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam int N     = 1 << IDX_W;

    logic [N-1:0]     valid_q;
    logic [1:0]       ctr_q [N];
    logic [TAG_W-1:0] tag_q [N];
    logic [PC_W-1:0]  tgt_q [N];

    logic             upd_hit;
    logic             upd_we;
    logic             valid_d;
    logic [1:0]       ctr_d;
    logic [TAG_W-1:0] tag_d;
    logic [PC_W-1:0]  tgt_d;

    assign lk_pred_taken_o  = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i) && ctr_q[lk_idx_i][1];
    assign lk_pred_target_o = tgt_q[lk_idx_i];

    assign upd_hit = valid_q[upd_idx_i] && (tag_q[upd_idx_i] == upd_tag_i);

    // New contents of the entry being trained: counter step on hit, allocate on taken miss.
    always_comb begin
        upd_we  = 1'b0;
        valid_d = valid_q[upd_idx_i];
        ctr_d   = ctr_q[upd_idx_i];
        tag_d   = tag_q[upd_idx_i];
        tgt_d   = tgt_q[upd_idx_i];
        if (upd_en_i) begin
            if (upd_hit) begin
                upd_we = 1'b1;
                ctr_d  = ctr_next(ctr_q[upd_idx_i], upd_taken_i);
                if (upd_taken_i) begin
                    tgt_d = upd_target_i;
                end
            end else if (upd_taken_i) begin
                upd_we  = 1'b1;
                valid_d = 1'b1;
                ctr_d   = WT;
                tag_d   = upd_tag_i;
                tgt_d   = upd_target_i;
            end
        end
    end

    // Table storage: clear on reset, otherwise write the single trained entry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            for (int i = 0; i < N; i++) begin
                ctr_q[i] <= WNT;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (upd_we) begin
            valid_q[upd_idx_i] <= valid_d;
            ctr_q[upd_idx_i]   <= ctr_d;
            tag_q[upd_idx_i]   <= tag_d;
            tgt_q[upd_idx_i]   <= tgt_d;
        end
    end

endmodule

// File: rtl/fetch_btb_stage.sv
// Instruction fetch stage: PC, BTB-predicted next PC, IF/ID register, redirect on mispredict.
// One cycle from pc to IF/ID; a redirect target is fetched the cycle after branch_taken.
// stall == 0 freezes pc and IF/ID, but a mispredict still redirects and inserts a bubble.
module fetch_btb_stage
    import fetch_btb_stage_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              BTB_IDX_W = 4,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] iaddr,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_pred_target,
    output logic [31:0]     idata,
    output logic [PC_W-1:0] id_pc,
    output logic            id_pred_taken,
    output logic [PC_W-1:0] id_pred_target,
    output logic            id_valid,
    output logic            branch_taken,
    output logic [15:0]     branch_cnt,
    output logic [15:0]     mispred_cnt
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     idata_q, idata_d;
    logic [PC_W-1:0] id_pc_q, id_pc_d;
    logic            id_pred_taken_q, id_pred_taken_d;
    logic [PC_W-1:0] id_pred_target_q, id_pred_target_d;
    logic            id_valid_q, id_valid_d;
    logic [15:0]     branch_cnt_q, branch_cnt_d;
    logic [15:0]     mispred_cnt_q, mispred_cnt_d;

    logic            resolved;
    logic            mispredict;
    logic [PC_W-1:0] redirect_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;

    assign resolved    = ex_valid && ex_is_branch;
    assign mispredict  = resolved && ((ex_taken != ex_pred_taken) ||
                                      (ex_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = ex_taken ? ex_target : ex_pc + PC_W'(4);

    btb_table #(
        .PC_W  (PC_W),
        .IDX_W (BTB_IDX_W)
    ) u_btb (
        .clk_i            (clk),
        .reset_i          (reset),
        .lk_idx_i         (pc_q[BTB_IDX_W+1:2]),
        .lk_tag_i         (pc_q[PC_W-1:BTB_IDX_W+2]),
        .lk_pred_taken_o  (pred_taken),
        .lk_pred_target_o (pred_target),
        .upd_en_i         (resolved),
        .upd_idx_i        (ex_pc[BTB_IDX_W+1:2]),
        .upd_tag_i        (ex_pc[PC_W-1:BTB_IDX_W+2]),
        .upd_taken_i      (ex_taken),
        .upd_target_i     (ex_target)
    );

    // PC and IF/ID next state: redirect with bubble beats hold, hold beats advance.
    always_comb begin
        pc_d             = pc_q;
        idata_d          = idata_q;
        id_pc_d          = id_pc_q;
        id_pred_taken_d  = id_pred_taken_q;
        id_pred_target_d = id_pred_target_q;
        id_valid_d       = id_valid_q;
        if (mispredict) begin
            pc_d             = redirect_pc;
            idata_d          = NOP_INSN;
            id_pc_d          = '0;
            id_pred_taken_d  = 1'b0;
            id_pred_target_d = '0;
            id_valid_d       = 1'b0;
        end else if (stall) begin
            pc_d             = pred_taken ? pred_target : pc_q + PC_W'(4);
            idata_d          = imem_rdata;
            id_pc_d          = pc_q;
            id_pred_taken_d  = pred_taken;
            id_pred_target_d = pred_target;
            id_valid_d       = 1'b1;
        end
    end

    // Saturating statistics counters.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolved && (branch_cnt_q != 16'hFFFF)) begin
            branch_cnt_d = branch_cnt_q + 16'd1;
        end
        if (mispredict && (mispred_cnt_q != 16'hFFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 16'd1;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q             <= RESET_PC;
            idata_q          <= NOP_INSN;
            id_pc_q          <= '0;
            id_pred_taken_q  <= 1'b0;
            id_pred_target_q <= '0;
            id_valid_q       <= 1'b0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            pc_q             <= pc_d;
            idata_q          <= idata_d;
            id_pc_q          <= id_pc_d;
            id_pred_taken_q  <= id_pred_taken_d;
            id_pred_target_q <= id_pred_target_d;
            id_valid_q       <= id_valid_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    assign iaddr          = pc_q;
    assign idata          = idata_q;
    assign id_pc          = id_pc_q;
    assign id_pred_taken  = id_pred_taken_q;
    assign id_pred_target = id_pred_target_q;
    assign id_valid       = id_valid_q;
    assign branch_taken   = mispredict;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

endmodule
